asg_seq_ctrl: RTL and testbench
===============================

# asg_seq_ctrl

Segment sequencer for one ASG channel. Holds a small table of waveform segments (offset, size, step, cycle count), loads each segment into the channel's configuration inputs and fires a software trigger. It counts end-of-buffer events and advances to the next segment, optionally looping. It sits between the register bus and the channel's `set_*` / `trig_sw_i` inputs; the channel's trigger source is set to software (1) by the register block whenever the sequencer is enabled.

## Interface
Parameters:
- `RSZ`, 14, buffer address bits; pointer fields are RSZ+16 bits wide.
- `NSEG`, 8, number of table entries (power of two, 2..64).
- `BLANK`, 3, cycles after the trigger pulse during which `wrap_i` is ignored.

Ports:
- `dac_clk_i` in 1: the only clock.
- `dac_rst_i` in 1: reset, synchronous, active-high.
- `cfg_we_i` in 1: table write strobe.
- `cfg_addr_i` in $clog2(NSEG)+2: {entry, field}; field 0 = ofs, 1 = size, 2 = step, 3 = ncyc.
- `cfg_wdata_i` in 32: write data; ofs/size/step use bits [RSZ+15:0].
- `seq_start_i` in 1: start pulse.
- `seq_stop_i` in 1: abort pulse.
- `seq_len_i` in $clog2(NSEG)+1: number of segments; 0 is treated as 1, values above NSEG clamp to NSEG.
- `seq_loop_i` in 1: after the last segment, restart at entry 0.
- `wrap_i` in 1: end-of-buffer pulse from the channel.
- `set_ofs_o`, `set_size_o`, `set_step_o` out RSZ+16: channel configuration.
- `set_ncyc_o` out 32: channel cycle count.
- `set_rst_o` out 1: channel FSM reset.
- `trig_sw_o` out 1: software trigger pulse.
- `seq_busy_o` out 1: high in any state except IDLE.
- `seq_idx_o` out $clog2(NSEG): index of the active segment.
- `seq_done_o` out 1: one-cycle pulse when the sequence completes.

## Operation
- States are IDLE, LOAD, ARM and RUN. All outputs are registered.
- **IDLE**
  - `set_rst_o`=1, `trig_sw_o`=0, `seq_busy_o`=0.
  - On `seq_start_i`: go to LOAD with idx=0.
- **LOAD** (one cycle)
  - Latch table[idx] into `set_*_o`.
  - `set_rst_o`=1, wrap counter := 0.
- **ARM** (BLANK+1 cycles)
  - First cycle: `set_rst_o`=0, `trig_sw_o`=1.
  - Remaining BLANK cycles: `trig_sw_o`=0 and `wrap_i` is masked.
  - Then go to RUN.
- **RUN**
  - Each `wrap_i` increments the 32-bit wrap counter.
  - When counter+1 == ncyc on a `wrap_i` cycle, the segment is finished:
    - if idx < len−1: idx+1, go to LOAD;
    - else if `seq_loop_i`: idx=0, go to LOAD;
    - else: `seq_done_o`=1 for one cycle, go to IDLE.
  - ncyc = 0 means the segment runs until `seq_stop_i`.
- `seq_stop_i` in any non-IDLE state goes to IDLE on the next edge with `set_rst_o`=1. It does not pulse `seq_done_o`.
- `seq_start_i` while busy is ignored.
- Table writes are accepted in every state. The `set_*_o` values are latched only in LOAD, so rewriting the active entry affects only its next load.
- `seq_len_i` and `seq_loop_i` are sampled at each segment end, not at start.
- Reset values:
  - state IDLE, idx 0, wrap counter 0, all table entries 0;
  - `set_rst_o`=1;
  - all other outputs 0.

## Timing
- `seq_start_i` high at edge k (IDLE):
  - k+1: LOAD; `set_*_o` valid, `set_rst_o`=1.
  - k+2: `trig_sw_o`=1, `set_rst_o`=0.
  - k+3 … k+2+BLANK: blanking, `wrap_i` ignored.
  - k+3+BLANK: RUN.
- Segment end: the `wrap_i` that finishes the segment is at edge m; m+1 is LOAD of the next segment. Inter-segment dead time is BLANK+2 cycles.
- Simultaneous events:
  - stop together with a finishing `wrap_i`: stop wins, no `seq_done_o`.
  - `cfg_we_i` to entry idx during the LOAD cycle: LOAD uses the old data.
  - start together with stop in IDLE: start is taken and stop is ignored.
- Reset asserted mid-RUN: the next edge gives reset values, and `set_rst_o`=1 holds the channel stopped.

## Structure
- Package `asg_seq_pkg`:
  - state enum;
  - field index constants FLD_OFS = 0, FLD_SIZE = 1, FLD_STEP = 2, FLD_NCYC = 3;
  - a segment record typedef {ofs, size, step, ncyc}.
- Sub-module `asg_seq_table`: NSEG-entry register file with one write port and combinational read by idx. The parent contains the FSM, wrap counter, blank counter and output registers.

## Test plan
- **Basic segment:** entry 0 = {ofs 0, size 0x3FFF_FFFF, step 0x10000, ncyc 2}, len 1, start at k.
  - `set_rst_o` falls and `trig_sw_o` pulses at k+2.
  - After the second post-blank `wrap_i`, `seq_done_o` pulses, then IDLE with `set_rst_o`=1.
- **Three segments, ncyc 1/2/3, loop off:**
  - `seq_idx_o` steps 0→1→2.
  - Exactly 6 counted wraps, and three `trig_sw_o` pulses each preceded by a LOAD.
- **Loop:** len 2, loop on, ncyc 1 each.
  - idx sequence 0,1,0,1…
  - After stop: IDLE within 1 cycle, no `seq_done_o`.
- **Blanking and infinite segment:**
  - `wrap_i` pulsed on the trigger cycle and the BLANK cycles is not counted.
  - ncyc = 0 never advances over 1000 wraps.
- **Edge cases:**
  - Start with len 0 runs one segment.
  - Stop on the same cycle as a finishing wrap gives no done pulse.
  - Reset mid-RUN gives all-zero outputs, `set_rst_o`=1, idx 0.
- **Table write during RUN:** rewriting the active entry's step leaves `set_step_o` unchanged until that entry is reloaded by looping.

Source files
------------

// File: rtl/asg_seq_pkg.sv
// rtl/asg_seq_pkg.sv - shared state, field and segment types for the ASG segment sequencer
package asg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [1:0] FLD_OFS  = 2'd0;
  localparam logic [1:0] FLD_SIZE = 2'd1;
  localparam logic [1:0] FLD_STEP = 2'd2;
  localparam logic [1:0] FLD_NCYC = 2'd3;

  typedef struct packed {
    logic [31:0] ofs;
    logic [31:0] size;
    logic [31:0] step;
    logic [31:0] ncyc;
  } seg_t;

  // Pointer fields only keep their low pw bits; pw may reach 32.
  function automatic logic [31:0] ptr_mask(input int pw);
    if (pw >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << pw) - 32'd1;
  endfunction

endpackage

// File: rtl/asg_seq_table.sv
// rtl/asg_seq_table.sv - segment table register file, one write port, combinational read
module asg_seq_table
  import asg_seq_pkg::*;
#(
  parameter int RSZ  = 14,
  parameter int NSEG = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NSEG)+1:0]     addr,
  input  logic [31:0]                 wdata,
  input  logic [$clog2(NSEG)-1:0]     rd_idx,
  output seg_t                        rd_seg
);

  localparam int          IW    = $clog2(NSEG);
  localparam logic [31:0] PMASK = ptr_mask(RSZ + 16);

  seg_t           mem [NSEG];
  logic [IW-1:0]  wr_idx;
  logic [1:0]     wr_fld;

  assign wr_idx = addr[IW+1:2];
  assign wr_fld = addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      case (wr_fld)
        FLD_OFS:  mem[wr_idx].ofs  <= wdata & PMASK;
        FLD_SIZE: mem[wr_idx].size <= wdata & PMASK;
        FLD_STEP: mem[wr_idx].step <= wdata & PMASK;
        default:  mem[wr_idx].ncyc <= wdata;
      endcase
    end
  end

  assign rd_seg = mem[rd_idx];

endmodule

// File: rtl/asg_seq_ctrl.sv
// rtl/asg_seq_ctrl.sv - segment sequencer: loads table entries into one ASG channel and triggers it
module asg_seq_ctrl
  import asg_seq_pkg::*;
#(
  parameter int RSZ   = 14,
  parameter int NSEG  = 8,
  parameter int BLANK = 3
) (
  input  logic                      dac_clk_i,
  input  logic                      dac_rst_i,
  input  logic                      cfg_we_i,
  input  logic [$clog2(NSEG)+1:0]   cfg_addr_i,
  input  logic [31:0]               cfg_wdata_i,
  input  logic                      seq_start_i,
  input  logic                      seq_stop_i,
  input  logic [$clog2(NSEG):0]     seq_len_i,
  input  logic                      seq_loop_i,
  input  logic                      wrap_i,
  output logic [RSZ+15:0]           set_ofs_o,
  output logic [RSZ+15:0]           set_size_o,
  output logic [RSZ+15:0]           set_step_o,
  output logic [31:0]               set_ncyc_o,
  output logic                      set_rst_o,
  output logic                      trig_sw_o,
  output logic                      seq_busy_o,
  output logic [$clog2(NSEG)-1:0]   seq_idx_o,
  output logic                      seq_done_o
);

  localparam int IW = $clog2(NSEG);
  localparam int LW = IW + 1;
  localparam int PW = RSZ + 16;
  localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  state_t         state_q, state_n;
  logic [IW-1:0]  idx_q, idx_n;
  logic [31:0]    wrap_q, wrap_n;
  logic [BW-1:0]  blank_q, blank_n;
  logic           done_n;
  logic [LW-1:0]  len_eff;
  logic           last_seg;
  logic           seg_end;
  seg_t           rd_seg, seg_q;
  logic           rst_q, trig_q, busy_q, done_q;

  // Read port follows the next index so the entering-LOAD edge latches the right entry.
  asg_seq_table #(
    .RSZ  (RSZ),
    .NSEG (NSEG)
  ) u_table (
    .clk    (dac_clk_i),
    .rst    (dac_rst_i),
    .we     (cfg_we_i),
    .addr   (cfg_addr_i),
    .wdata  (cfg_wdata_i),
    .rd_idx (idx_n),
    .rd_seg (rd_seg)
  );

  always_comb begin
    len_eff = seq_len_i;
    if (seq_len_i == '0) begin
      len_eff = LW'(1);
    end else if (seq_len_i > LW'(NSEG)) begin
      len_eff = LW'(NSEG);
    end
  end

  assign last_seg = ({1'b0, idx_q} >= (len_eff - LW'(1)));
  assign seg_end  = (seg_q.ncyc != 32'd0) && ((wrap_q + 32'd1) == seg_q.ncyc);

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    wrap_n  = wrap_q;
    blank_n = blank_q;
    done_n  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seq_start_i) begin
          state_n = ST_LOAD;
          idx_n   = '0;
        end
      end
      ST_LOAD: begin
        state_n = ST_ARM;
        blank_n = '0;
        wrap_n  = '0;
      end
      ST_ARM: begin
        if (blank_q == BW'(BLANK)) begin
          state_n = ST_RUN;
        end else begin
          blank_n = blank_q + BW'(1);
        end
      end
      ST_RUN: begin
        if (wrap_i) begin
          if (seg_end) begin
            if (!last_seg) begin
              idx_n   = idx_q + IW'(1);
              state_n = ST_LOAD;
            end else if (seq_loop_i) begin
              idx_n   = '0;
              state_n = ST_LOAD;
            end else begin
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end
          end else begin
            wrap_n = wrap_q + 32'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Abort overrides everything, including a finishing wrap.
    if ((state_q != ST_IDLE) && seq_stop_i) begin
      state_n = ST_IDLE;
      idx_n   = idx_q;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wrap_q  <= '0;
      blank_q <= '0;
      seg_q   <= '0;
      rst_q   <= 1'b1;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      wrap_q  <= wrap_n;
      blank_q <= blank_n;
      if ((state_n == ST_LOAD) && (state_q != ST_LOAD)) begin
        seg_q <= rd_seg;
      end
      rst_q  <= (state_n == ST_IDLE) || (state_n == ST_LOAD);
      trig_q <= (state_q == ST_LOAD) && (state_n == ST_ARM);
      busy_q <= (state_n != ST_IDLE);
      done_q <= done_n;
    end
  end

  assign set_ofs_o  = seg_q.ofs[PW-1:0];
  assign set_size_o = seg_q.size[PW-1:0];
  assign set_step_o = seg_q.step[PW-1:0];
  assign set_ncyc_o = seg_q.ncyc;
  assign set_rst_o  = rst_q;
  assign trig_sw_o  = trig_q;
  assign seq_busy_o = busy_q;
  assign seq_idx_o  = idx_q;
  assign seq_done_o = done_q;

endmodule

// File: tb/tb_asg_seq_ctrl.sv
// tb/tb_asg_seq_ctrl.sv - scoreboard bench for asg_seq_ctrl with a timeline-based reference model
module tb_asg_seq_ctrl;

  localparam int RSZ   = 14;
  localparam int NSEG  = 8;
  localparam int BLANK = 3;
  localparam int IW    = 3;
  localparam int LW    = 4;
  localparam int AW    = 5;
  localparam int PW    = 30;
  localparam logic [31:0] PMASK = 32'h3FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          start = 1'b0, stop = 1'b0, loop = 1'b0, wrap = 1'b0;
  logic [LW-1:0] len = LW'(1);
  logic [PW-1:0] set_ofs, set_size, set_step;
  logic [31:0]   set_ncyc;
  logic          set_rst, trig, busy, done;
  logic [IW-1:0] idx;

  always #5 clk = ~clk;

  asg_seq_ctrl #(.RSZ(RSZ), .NSEG(NSEG), .BLANK(BLANK)) dut (
    .dac_clk_i   (clk),
    .dac_rst_i   (rst),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .seq_start_i (start),
    .seq_stop_i  (stop),
    .seq_len_i   (len),
    .seq_loop_i  (loop),
    .wrap_i      (wrap),
    .set_ofs_o   (set_ofs),
    .set_size_o  (set_size),
    .set_step_o  (set_step),
    .set_ncyc_o  (set_ncyc),
    .set_rst_o   (set_rst),
    .trig_sw_o   (trig),
    .seq_busy_o  (busy),
    .seq_idx_o   (idx),
    .seq_done_o  (done)
  );

  int checks = 0, failures = 0;
  int edge_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: a segment started at edge e loads at e, triggers at e+1,
  // and counts wraps sampled from edge e+3+BLANK onwards.
  logic [31:0] m_tab [NSEG][4];
  logic [31:0] m_seg [4];
  bit          m_busy = 0;
  int          m_idx = 0;
  logic [31:0] m_cnt = '0;
  int          m_load_at = -100, m_trig_at = -100, m_live_at = 0;
  int          n_trig_exp = 0;

  typedef struct { int at; int idx; } trig_t;
  typedef struct {
    int at; bit busy; bit rst; int idx;
    logic [31:0] ofs; logic [31:0] size; logic [31:0] step; logic [31:0] ncyc;
  } stat_t;
  trig_t trig_q[$];
  int    done_q[$];
  stat_t stat_q[$];

  task automatic seg_begin(input int i, input int e);
    m_idx = i;
    for (int f = 0; f < 4; f++) m_seg[f] = m_tab[i][f];
    m_cnt     = '0;
    m_load_at = e;
    m_trig_at = e + 1;
    m_live_at = e + 3 + BLANK;
  endtask

  task automatic model_edge(input int e);
    int len_eff;
    if (rst) begin
      m_busy = 0; m_idx = 0; m_cnt = '0; m_load_at = -100; m_trig_at = -100;
      for (int f = 0; f < 4; f++) m_seg[f] = '0;
      for (int i = 0; i < NSEG; i++) for (int f = 0; f < 4; f++) m_tab[i][f] = '0;
    end else begin
      if (!m_busy) begin
        if (start) begin m_busy = 1; seg_begin(0, e); end
      end else if (stop) begin
        m_busy = 0;
      end else begin
        if (e == m_trig_at) begin trig_q.push_back('{e, m_idx}); n_trig_exp++; end
        if (wrap && e >= m_live_at) begin
          if (m_seg[3] != 0 && m_cnt + 1 == m_seg[3]) begin
            len_eff = (len == 0) ? 1 : ((int'(len) > NSEG) ? NSEG : int'(len));
            if (m_idx < len_eff - 1) seg_begin(m_idx + 1, e);
            else if (loop) seg_begin(0, e);
            else begin m_busy = 0; done_q.push_back(e); end
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      if (cfg_we)
        m_tab[cfg_addr[AW-1:2]][cfg_addr[1:0]] = (cfg_addr[1:0] == 2'd3) ? cfg_wdata : (cfg_wdata & PMASK);
    end
    stat_q.push_back('{e, m_busy, (!m_busy || e == m_load_at), m_idx,
                       m_seg[0], m_seg[1], m_seg[2], m_seg[3]});
  endtask

  function automatic bit would_finish();
    return m_busy && !stop && (edge_n + 1 >= m_live_at) && m_seg[3] != 0 && (m_cnt + 1 == m_seg[3]);
  endfunction

  // Monitor: compares every cycle against what the model queued for that edge.
  int mon_trig = 0, mon_done = 0;
  stat_t st;
  trig_t tq;
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      st = stat_q.pop_front();
      chk("stat_edge", edge_n, st.at);
      chk("busy", busy, st.busy);
      chk("set_rst", set_rst, st.rst);
      chk("idx", idx, st.idx);
      chk("set_ofs", set_ofs, st.ofs);
      chk("set_size", set_size, st.size);
      chk("set_step", set_step, st.step);
      chk("set_ncyc", set_ncyc, st.ncyc);
      if (trig) mon_trig++;
      if (done) mon_done++;
      if (trig_q.size() > 0 && trig_q[0].at == edge_n) begin
        tq = trig_q.pop_front();
        chk("trig_pulse", trig, 1);
        chk("trig_idx", idx, tq.idx);
      end else begin
        chk("trig_quiet", trig, 0);
      end
      if (done_q.size() > 0 && done_q[0] == edge_n) begin
        void'(done_q.pop_front());
        chk("done_pulse", done, 1);
      end else begin
        chk("done_quiet", done, 0);
      end
    end
  end

  task automatic step();
    model_edge(edge_n + 1);
    @(posedge clk);
    edge_n++;
    #1;
    start = 0; stop = 0; cfg_we = 0; wrap = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int entry, input int fld, input logic [31:0] data);
    cfg_we = 1; cfg_addr = AW'((entry << 2) | fld); cfg_wdata = data;
    step();
  endtask

  task automatic load_entry(input int e, input logic [31:0] o, input logic [31:0] s,
                            input logic [31:0] p, input logic [31:0] n);
    wr(e, 0, o); wr(e, 1, s); wr(e, 2, p); wr(e, 3, n);
  endtask

  task automatic run_seq(input int budget, input int pct, input bit stop_fin, input bit rand_wr);
    int n = 0;
    while (m_busy && n < budget) begin
      wrap = ($urandom_range(0, 99) < pct);
      if (stop_fin && wrap && would_finish()) stop = 1;
      if (rand_wr && $urandom_range(0, 9) == 0) begin
        cfg_we = 1;
        cfg_addr = AW'($urandom_range(0, 31));
        cfg_wdata = (cfg_addr[1:0] == 2'd3) ? 32'($urandom_range(1, 3)) : $urandom;
      end
      step();
      n++;
    end
    chk("seq_returned_idle", busy, 0);
  endtask

  int mt0, md0, et0;
  logic [31:0] a_step, b_step;

  initial begin
    rst = 1;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_set_rst", set_rst, 1);
    chk("reset_trig", trig, 0);
    chk("reset_done", done, 0);
    chk("reset_idx", idx, 0);
    chk("reset_ncyc", set_ncyc, 0);
    rst = 0;
    step();

    // Basic single segment
    load_entry(0, 32'h0, 32'h3FFF_FFFF, 32'h0001_0000, 32'd2);
    len = 1; loop = 0;
    settle(); md0 = mon_done; mt0 = mon_trig;
    start = 1; step();
    chk("t1_rst_in_load", set_rst, 1);
    step();
    chk("t1_trig_k2", trig, 1);
    chk("t1_rst_low_k2", set_rst, 0);
    run_seq(300, 30, 0, 0);
    settle();
    chk("t1_done_cnt", mon_done - md0, 1);
    chk("t1_trig_cnt", mon_trig - mt0, 1);

    // Three segments, no loop
    for (int i = 0; i < 3; i++) load_entry(i, $urandom, $urandom, $urandom, 32'(i + 1));
    len = 3;
    settle(); md0 = mon_done; mt0 = mon_trig;
    start = 1; step();
    run_seq(400, 40, 0, 0);
    settle();
    chk("t2_trig_cnt", mon_trig - mt0, 3);
    chk("t2_done_cnt", mon_done - md0, 1);

    // Looping two segments, then abort
    load_entry(0, $urandom, $urandom, $urandom, 32'd1);
    load_entry(1, $urandom, $urandom, $urandom, 32'd1);
    len = 2; loop = 1;
    settle(); md0 = mon_done; mt0 = mon_trig; et0 = n_trig_exp;
    start = 1; step();
    repeat (80) begin wrap = ($urandom_range(0, 1) == 1); step(); end
    stop = 1; step();
    chk("t3_stop_idle", busy, 0);
    settle();
    chk("t3_trig_vs_model", mon_trig - mt0, n_trig_exp - et0);
    chk("t3_no_done", mon_done - md0, 0);
    loop = 0;

    // Blanking with wrap held high, then an infinite segment
    load_entry(0, $urandom, $urandom, $urandom, 32'd2);
    len = 1;
    settle(); md0 = mon_done;
    start = 1; step();
    run_seq(50, 100, 0, 0);
    settle();
    chk("t4_blank_done", mon_done - md0, 1);
    wr(0, 3, 32'd0);
    settle(); mt0 = mon_trig;
    start = 1; step();
    repeat (1010) begin wrap = 1; step(); end
    chk("t4_inf_busy", busy, 1);
    chk("t4_inf_idx", idx, 0);
    stop = 1; step();
    settle();
    chk("t4_inf_trig_cnt", mon_trig - mt0, 1);

    // len 0 behaves as one segment
    load_entry(0, $urandom, $urandom, $urandom, 32'd1);
    load_entry(1, $urandom, $urandom, $urandom, 32'd1);
    len = 0;
    settle(); md0 = mon_done; mt0 = mon_trig;
    start = 1; step();
    run_seq(200, 50, 0, 0);
    settle();
    chk("t5_len0_trig", mon_trig - mt0, 1);
    chk("t5_len0_done", mon_done - md0, 1);

    // Stop coincident with the finishing wrap
    len = 1;
    wr(0, 3, 32'd2);
    settle(); md0 = mon_done;
    start = 1; step();
    run_seq(200, 40, 1, 0);
    settle();
    chk("t6_stop_wins", mon_done - md0, 0);

    // Reset while running
    wr(0, 3, 32'd0);
    start = 1; step();
    repeat (10) begin wrap = 1; step(); end
    rst = 1; step(); rst = 0;
    chk("t7_busy", busy, 0);
    chk("t7_set_rst", set_rst, 1);
    chk("t7_idx", idx, 0);
    chk("t7_ofs", set_ofs, 0);
    chk("t7_step", set_step, 0);
    chk("t7_ncyc", set_ncyc, 0);

    // Rewrite the active entry's step while it runs
    a_step = $urandom; b_step = a_step ^ 32'h0000_5A5A;
    load_entry(0, $urandom, $urandom, a_step, 32'd3);
    len = 1; loop = 1;
    start = 1; step();
    repeat (10) step();
    wr(0, 2, b_step);
    chk("t8_step_hold", set_step, a_step & PMASK);
    for (int n = 0; n < 300 && m_seg[2] != (b_step & PMASK); n++) begin
      wrap = ($urandom_range(0, 1) == 1); step();
    end
    chk("t8_step_new", set_step, b_step & PMASK);
    stop = 1; step();
    loop = 0;

    // Randomized sequences with table writes in flight
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NSEG; i++) load_entry(i, $urandom, $urandom, $urandom, 32'($urandom_range(1, 3)));
      len = LW'($urandom_range(0, 15));
      settle(); md0 = mon_done;
      start = 1; step();
      run_seq(600, 35, 0, 1);
      settle();
      chk("t9_done", mon_done - md0, 1);
    end

    step(); step();
    settle();
    chk("queues_drained", trig_q.size() + done_q.size() + stat_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
